vga_controller: RTL and testbench
=================================

VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-003 Parameter H_FRONT, default 16, horizontal front porch in pixel clocks.
REQ-004 Parameter H_SYNC, default 96, horizontal sync width in pixel clocks.
REQ-005 Parameter H_BACK, default 48, horizontal back porch in pixel clocks.
REQ-006 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-007 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-008 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-009 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-010 Port clk_i, input, 1 bit: pixel clock; all state updates on its rising edge.
REQ-011 Port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-012 Port Enable_i, input, 1 bit: pixel-advance enable; counters hold while low.
REQ-013 Port x_o, output, 10 bits: horizontal counter, 0..H_TOTAL-1.
REQ-014 Port y_o, output, 10 bits: vertical counter, 0..V_TOTAL-1.
REQ-015 Port h_sync_o, output, 1 bit: horizontal sync, active low.
REQ-016 Port v_sync_o, output, 1 bit: vertical sync, active low.

Function
REQ-017 H_TOTAL SHALL be the sum of the four H parameters (800 by default); V_TOTAL SHALL be the sum of the four V parameters (525 by default).
REQ-018 Each horizontal line SHALL be ordered: visible, then front porch, then sync, then back porch; vertical timing SHALL use the same order.
REQ-019 On a clock edge with Enable_i=1 and rst_i=0, x_o SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0 on the next enabled edge.
REQ-020 y_o SHALL increment only on the enabled edge where x_o wraps from H_TOTAL-1 to 0; at V_TOTAL-1 on that edge it SHALL wrap to 0.
REQ-021 With Enable_i=0, x_o, y_o, h_sync_o and v_sync_o SHALL hold their values.
REQ-022 h_sync_o SHALL be 0 exactly when H_VISIBLE+H_FRONT <= x_o < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default), and 1 otherwise.
REQ-023 v_sync_o SHALL be 0 exactly when V_VISIBLE+V_FRONT <= y_o < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default), and 1 otherwise.
REQ-024 All outputs SHALL be registered; sync outputs SHALL be decoded from the next-state counter values so that they are cycle-aligned with x_o/y_o, with zero latency relative to the counters.
REQ-025 Arithmetic SHALL be unsigned 10 bits; parameter totals SHALL NOT exceed 1024, and a total above 1024 is a configuration error.

Reset
REQ-026 When rst_i=1 at a clock edge, x_o SHALL become 0, y_o 0, h_sync_o 1 and v_sync_o 1, regardless of Enable_i.
REQ-027 Reset SHALL take priority over Enable_i; reset asserted mid-frame SHALL restart the frame at (0,0) on the next edge.
REQ-028 After reset deasserts, the first enabled edge SHALL produce x_o=1, y_o=0.

Structure
REQ-029 Timing parameter defaults and derived constants (H_TOTAL, V_TOTAL, sync start/end) SHALL reside in a shared package, vga_timing_pkg.
REQ-030 One sub-module SHALL be used: vga_axis_counter (wrapping counter with enable, terminal-count output and active-low sync-window decode), instantiated once per axis.

Verification
REQ-031 Reset: pulse rst_i for 1 cycle with Enable_i=1 -> x_o=0, y_o=0, h_sync_o=1, v_sync_o=1; next edge gives x_o=1.
REQ-032 Line wrap: run 799 enabled cycles from reset -> x_o=799, y_o=0; the next edge gives x_o=0, y_o=1.
REQ-033 H sync: h_sync_o falls at x_o=656 and rises at x_o=752; count exactly 96 low cycles per line.
REQ-034 Frame: from reset, 525*800=420000 enabled cycles -> x_o=0, y_o=0; v_sync_o is low only for y_o 490..491, for 1600 cycles.
REQ-035 Enable hold: deassert Enable_i for 5 cycles at x_o=100 -> all outputs frozen, then counting resumes at 101.
REQ-036 Mid-frame reset: assert rst_i at x_o=700, y_o=491 with Enable_i=1 -> next edge gives (0,0), h_sync_o=1, v_sync_o=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing defaults and derived constants
// Purpose: 640x480@60 default timing, counter width, and helpers that derive
//          axis totals and sync-window bounds from the four segment lengths.
// Ports: none (package).
package vga_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int axis_total(input int vis, input int front,
                                    input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  // Segments run visible, front porch, sync, back porch, so the sync window
  // opens right after the front porch.
  function automatic int sync_start(input int vis, input int front);
    return vis + front;
  endfunction

  function automatic int sync_end(input int vis, input int front, input int sync);
    return vis + front + sync;
  endfunction

  localparam int H_TOTAL_DEF      = axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int H_SYNC_START_DEF = sync_start(H_VISIBLE_DEF, H_FRONT_DEF);
  localparam int H_SYNC_END_DEF   = sync_end(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF);

  localparam int V_TOTAL_DEF      = axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
  localparam int V_SYNC_START_DEF = sync_start(V_VISIBLE_DEF, V_FRONT_DEF);
  localparam int V_SYNC_END_DEF   = sync_end(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping axis counter with terminal count and sync decode
// Purpose: counts 0..TOTAL-1 on enabled edges, wraps to 0, and registers an
//          active-low sync flag decoded from the next count so both flops
//          always agree on the same cycle.
// Ports:
//   clk_i    - pixel clock
//   rst_i    - synchronous active-high reset (count 0, sync high)
//   en_i     - advance enable; count and sync hold while low
//   count_o  - registered count
//   tc_o     - high while count_o sits at TOTAL-1
//   sync_n_o - registered, low while SYNC_START <= count_o < SYNC_END
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL_DEF,
  parameter int SYNC_START = H_SYNC_START_DEF,
  parameter int SYNC_END   = H_SYNC_END_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o,
  output logic             sync_n_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  // One extra bit so a sync window ending exactly at 1024 still compares correctly.
  localparam logic [CNT_W:0] START_X = (CNT_W + 1)'(SYNC_START);
  localparam logic [CNT_W:0] END_X   = (CNT_W + 1)'(SYNC_END);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_n_q, sync_n_d;

  assign tc_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
    // Decode from count_d so the registered sync lines up with the registered count.
    sync_n_d = !(({1'b0, count_d} >= START_X) && ({1'b0, count_d} < END_X));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      sync_n_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign count_o  = count_q;
  assign sync_n_o = sync_n_q;

endmodule

// File: rtl/vga_controller.sv
// rtl/vga_controller.sv - VGA raster timing generator
// Purpose: generates pixel/line counters and active-low sync pulses for a
//          parameterised raster; one axis counter per direction, the vertical
//          one advancing only when the horizontal one wraps.
// Ports:
//   clk_i    - pixel clock
//   rst_i    - synchronous active-high reset, overrides Enable_i
//   Enable_i - pixel-advance enable; all outputs hold while low
//   x_o      - horizontal counter 0..H_TOTAL-1
//   y_o      - vertical counter 0..V_TOTAL-1
//   h_sync_o - horizontal sync, active low
//   v_sync_o - vertical sync, active low
module vga_controller
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             Enable_i,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             h_sync_o,
  output logic             v_sync_o
);

  localparam int H_TOTAL      = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL      = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int H_SYNC_START = sync_start(H_VISIBLE, H_FRONT);
  localparam int H_SYNC_END   = sync_end(H_VISIBLE, H_FRONT, H_SYNC);
  localparam int V_SYNC_START = sync_start(V_VISIBLE, V_FRONT);
  localparam int V_SYNC_END   = sync_end(V_VISIBLE, V_FRONT, V_SYNC);

  // A total beyond the 10-bit range cannot be represented by the counters.
  if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
    $error("vga_controller: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
    $error("vga_controller: V_TOTAL exceeds 1024");
  end

  logic h_tc;
  logic v_tc_unused;
  logic v_en;

  // The line counter steps on exactly the enabled edge where x wraps.
  assign v_en = Enable_i & h_tc;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END)
  ) u_h_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (Enable_i),
    .count_o  (x_o),
    .tc_o     (h_tc),
    .sync_n_o (h_sync_o)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END)
  ) u_v_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (v_en),
    .count_o  (y_o),
    .tc_o     (v_tc_unused),
    .sync_n_o (v_sync_o)
  );

endmodule

// File: tb/tb_vga_controller.sv
// tb/tb_vga_controller.sv - self-checking bench for vga_controller
module tb_vga_controller;

  localparam int H_VIS = 640, H_FP = 16, H_SW = 96, H_BP = 48;
  localparam int V_VIS = 6,   V_FP = 2,  V_SW = 2,  V_BP = 3;
  localparam int HT = H_VIS + H_FP + H_SW + H_BP;
  localparam int VT = V_VIS + V_FP + V_SW + V_BP;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       Enable_i = 1'b0;
  logic [9:0] x_o, y_o;
  logic       h_sync_o, v_sync_o;

  int checks = 0;
  int errors = 0;
  int p = 0;  // enabled-edge count since reset, modulo one frame

  always #5 clk = ~clk;

  vga_controller #(
    .H_VISIBLE (H_VIS), .H_FRONT (H_FP), .H_SYNC (H_SW), .H_BACK (H_BP),
    .V_VISIBLE (V_VIS), .V_FRONT (V_FP), .V_SYNC (V_SW), .V_BACK (V_BP)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .Enable_i (Enable_i),
    .x_o      (x_o),
    .y_o      (y_o),
    .h_sync_o (h_sync_o),
    .v_sync_o (v_sync_o)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int mx();
    return p % HT;
  endfunction

  function automatic int my();
    return (p / HT) % VT;
  endfunction

  function automatic int mhs();
    return (mx() >= H_VIS + H_FP && mx() < H_VIS + H_FP + H_SW) ? 0 : 1;
  endfunction

  function automatic int mvs();
    return (my() >= V_VIS + V_FP && my() < V_VIS + V_FP + V_SW) ? 0 : 1;
  endfunction

  task automatic step(input logic en_v, input logic rst_v);
    Enable_i = en_v;
    rst_i    = rst_v;
    @(posedge clk);
    #1;
    if (rst_v) p = 0;
    else if (en_v) p = (p + 1) % FRAME;
    check_eq("model_x", int'(x_o), mx());
    check_eq("model_y", int'(y_o), my());
    check_eq("model_hs", int'(h_sync_o), mhs());
    check_eq("model_vs", int'(v_sync_o), mvs());
  endtask

  task automatic run_to(input int tx, input int ty);
    for (int i = 0; i < FRAME && !(mx() == tx && my() == ty); i++) step(1'b1, 1'b0);
    check_eq("run_to_x", int'(x_o), tx);
    check_eq("run_to_y", int'(y_o), ty);
  endtask

  initial begin
    int lows, fall_x, rise_x, vlows;
    logic prev;

    // Reset with enable high, then the first enabled edge.
    step(1'b1, 1'b1);
    check_eq("rst_x", int'(x_o), 0);
    check_eq("rst_y", int'(y_o), 0);
    check_eq("rst_hs", int'(h_sync_o), 1);
    check_eq("rst_vs", int'(v_sync_o), 1);
    step(1'b1, 1'b0);
    check_eq("first_x", int'(x_o), 1);
    check_eq("first_y", int'(y_o), 0);

    // Line wrap.
    step(1'b1, 1'b1);
    for (int i = 0; i < HT - 1; i++) step(1'b1, 1'b0);
    check_eq("line_end_x", int'(x_o), HT - 1);
    check_eq("line_end_y", int'(y_o), 0);
    step(1'b1, 1'b0);
    check_eq("wrap_x", int'(x_o), 0);
    check_eq("wrap_y", int'(y_o), 1);

    // Horizontal sync window over one full line.
    step(1'b1, 1'b1);
    lows = 0; fall_x = -1; rise_x = -1; prev = 1'b1;
    for (int i = 0; i < HT; i++) begin
      step(1'b1, 1'b0);
      if (!h_sync_o) lows++;
      if (prev && !h_sync_o) fall_x = int'(x_o);
      if (!prev && h_sync_o) rise_x = int'(x_o);
      prev = h_sync_o;
    end
    check_eq("hs_low_cycles", lows, H_SW);
    check_eq("hs_fall_x", fall_x, H_VIS + H_FP);
    check_eq("hs_rise_x", rise_x, H_VIS + H_FP + H_SW);

    // Full frame.
    step(1'b1, 1'b1);
    vlows = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, 1'b0);
      if (!v_sync_o) vlows++;
    end
    check_eq("frame_x", int'(x_o), 0);
    check_eq("frame_y", int'(y_o), 0);
    check_eq("vs_low_cycles", vlows, V_SW * HT);

    // Enable hold at x=100.
    step(1'b1, 1'b1);
    run_to(100, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check_eq("hold_x", int'(x_o), 100);
      check_eq("hold_y", int'(y_o), 0);
    end
    step(1'b1, 1'b0);
    check_eq("resume_x", int'(x_o), 101);

    // Mid-frame reset inside both sync windows.
    run_to(700, V_VIS + V_FP + V_SW - 1);
    check_eq("pre_rst_hs", int'(h_sync_o), 0);
    check_eq("pre_rst_vs", int'(v_sync_o), 0);
    step(1'b1, 1'b1);
    check_eq("mid_rst_x", int'(x_o), 0);
    check_eq("mid_rst_y", int'(y_o), 0);
    check_eq("mid_rst_hs", int'(h_sync_o), 1);
    check_eq("mid_rst_vs", int'(v_sync_o), 1);

    // Random enable pattern with occasional reset, checked against the model.
    for (int i = 0; i < 24000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4999) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
